// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the PC, reads
//   instruction memory combinationally and predicts the next PC with an agree
//   predictor: a direct-mapped BTB storing a per-branch bias bit, plus a PHT of
//   2-bit agree counters indexed by PC xor the global history register (GHR).
//   Drives the IF/ID pipeline register consumed by decode.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_stall_f             hold the PC
//   i_stall_d             hold the IF/ID register
//   i_flush_d             clear the IF/ID register (bubble)
//   i_redirect_e          execute detected a mispredict
//   i_redirect_pc_e       correct next PC
//   i_upd_vld_e           a branch/jump resolved in execute this cycle
//   i_upd_pc_e            PC of the resolved instruction
//   i_upd_target_e        resolved target
//   i_upd_taken_e         resolved direction
//   i_upd_is_jump_e       resolved instruction is JAL/JALR
//   i_imem_rdata          instruction at o_imem_addr (same cycle)
//   o_imem_addr           current PC
//   o_instr_d, o_pc_d, o_pc_four_d, o_predicted_pc_d, o_taken_d
//                         IF/ID register outputs
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned PHT_ENTRIES = 16,
    parameter int unsigned GHR_BITS    = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_f,
    input  logic        i_stall_d,
    input  logic        i_flush_d,
    input  logic        i_redirect_e,
    input  logic [31:0] i_redirect_pc_e,
    input  logic        i_upd_vld_e,
    input  logic [31:0] i_upd_pc_e,
    input  logic [31:0] i_upd_target_e,
    input  logic        i_upd_taken_e,
    input  logic        i_upd_is_jump_e,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc_four_d,
    output logic [31:0] o_predicted_pc_d,
    output logic        o_taken_d
);

    localparam int unsigned BI = $clog2(BTB_ENTRIES);
    localparam int unsigned PI = $clog2(PHT_ENTRIES);
    localparam int unsigned TW = 32 - BI - 2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]            r_pc;

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [BTB_ENTRIES-1:0] r_btb_bias;
    logic [BTB_ENTRIES-1:0] r_btb_jump;
    logic [TW-1:0]          r_btb_tag    [BTB_ENTRIES];
    logic [31:0]            r_btb_target [BTB_ENTRIES];

    logic [1:0]             r_pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0]    r_ghr;

    logic [31:0]            r_instr_d;
    logic [31:0]            r_pc_d;
    logic [31:0]            r_pc_four_d;
    logic [31:0]            r_predicted_pc_d;
    logic                   r_taken_d;

    // -------------------------------------------------------------------------
    // Lookup path (combinational on the current PC)
    // -------------------------------------------------------------------------
    logic [BI-1:0] w_btb_idx;
    logic [TW-1:0] w_tag;
    logic          w_hit;
    logic [PI-1:0] w_ghr_ext;
    logic [PI-1:0] w_pht_idx;
    logic          w_agree;
    logic          w_taken_f;
    logic [31:0]   w_pc_four;
    logic [31:0]   w_pred_pc;

    // GHR is zero-extended to the PHT index width before hashing.
    assign w_ghr_ext = PI'(r_ghr);

    assign w_btb_idx = r_pc[BI+1:2];
    assign w_tag     = r_pc[31:BI+2];
    assign w_hit     = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_tag);
    assign w_pht_idx = r_pc[PI+1:2] ^ w_ghr_ext;
    assign w_agree   = r_pht[w_pht_idx][1];

    // Jumps are always taken on a hit; conditional branches are taken when the
    // agree counter confirms the stored bias.
    assign w_taken_f = w_hit &
                       (r_btb_jump[w_btb_idx] | (r_btb_bias[w_btb_idx] == w_agree));
    assign w_pc_four = r_pc + 32'd4;
    assign w_pred_pc = w_taken_f ? r_btb_target[w_btb_idx] : w_pc_four;

    assign o_imem_addr = r_pc;

    // -------------------------------------------------------------------------
    // Update path (resolved branch/jump from execute)
    // -------------------------------------------------------------------------
    logic [BI-1:0] w_upd_btb_idx;
    logic [TW-1:0] w_upd_tag;
    logic          w_upd_hit;
    logic [PI-1:0] w_upd_pht_idx;
    logic          w_upd_is_branch;
    logic [1:0]    w_upd_cnt;
    logic [1:0]    w_upd_cnt_next;
    logic          w_unused_ok;

    // Low PC bits carry no index/tag information.
    assign w_unused_ok = &{1'b0, i_upd_pc_e[1:0]};

    assign w_upd_btb_idx   = i_upd_pc_e[BI+1:2];
    assign w_upd_tag       = i_upd_pc_e[31:BI+2];
    assign w_upd_hit       = r_btb_valid[w_upd_btb_idx] &&
                             (r_btb_tag[w_upd_btb_idx] == w_upd_tag);
    assign w_upd_pht_idx   = i_upd_pc_e[PI+1:2] ^ w_ghr_ext;
    assign w_upd_is_branch = ~i_upd_is_jump_e;
    assign w_upd_cnt       = r_pht[w_upd_pht_idx];

    // Counter trains toward "agree" when the outcome matches the stored bias,
    // saturating at both ends.
    always_comb begin
        w_upd_cnt_next = w_upd_cnt;
        if (i_upd_taken_e == r_btb_bias[w_upd_btb_idx]) begin
            if (w_upd_cnt != 2'd3) begin
                w_upd_cnt_next = w_upd_cnt + 2'd1;
            end
        end else begin
            if (w_upd_cnt != 2'd0) begin
                w_upd_cnt_next = w_upd_cnt - 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // PC and IF/ID register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc             <= RESET_PC;
            r_instr_d        <= '0;
            r_pc_d           <= '0;
            r_pc_four_d      <= '0;
            r_predicted_pc_d <= '0;
            r_taken_d        <= 1'b0;
        end else begin
            // Redirect wins over a fetch stall.
            if (i_redirect_e) begin
                r_pc <= i_redirect_pc_e;
            end else if (!i_stall_f) begin
                r_pc <= w_pred_pc;
            end

            if (i_flush_d) begin
                r_instr_d        <= '0;
                r_pc_d           <= '0;
                r_pc_four_d      <= '0;
                r_predicted_pc_d <= '0;
                r_taken_d        <= 1'b0;
            end else if (!i_stall_d) begin
                r_instr_d        <= i_imem_rdata;
                r_pc_d           <= r_pc;
                r_pc_four_d      <= w_pc_four;
                r_predicted_pc_d <= w_pred_pc;
                r_taken_d        <= w_taken_f;
            end
        end
    end

    assign o_instr_d        = r_instr_d;
    assign o_pc_d           = r_pc_d;
    assign o_pc_four_d      = r_pc_four_d;
    assign o_predicted_pc_d = r_predicted_pc_d;
    assign o_taken_d        = r_taken_d;

    // -------------------------------------------------------------------------
    // Predictor tables. Lookup above reads pre-edge contents, so a same-cycle
    // update to the looked-up entry becomes visible only after this edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_btb_valid <= '0;
            r_btb_bias  <= '0;
            r_btb_jump  <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
            end
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
                r_pht[i] <= 2'b10;
            end
            r_ghr <= '0;
        end else if (i_upd_vld_e) begin
            if (w_upd_hit) begin
                r_btb_target[w_upd_btb_idx] <= i_upd_target_e;
                if (w_upd_is_branch) begin
                    r_pht[w_upd_pht_idx] <= w_upd_cnt_next;
                end
            end else if (i_upd_taken_e) begin
                r_btb_valid[w_upd_btb_idx]  <= 1'b1;
                r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
                r_btb_target[w_upd_btb_idx] <= i_upd_target_e;
                r_btb_bias[w_upd_btb_idx]   <= i_upd_taken_e;
                r_btb_jump[w_upd_btb_idx]   <= i_upd_is_jump_e;
                // Jumps never touch the PHT, including on allocation.
                if (w_upd_is_branch) begin
                    r_pht[w_upd_pht_idx] <= 2'b10;
                end
            end

            if (w_upd_is_branch) begin
                r_ghr <= (r_ghr << 1) | GHR_BITS'(i_upd_taken_e);
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Directly upstream of decode.
- Holds the PC and reads instruction memory combinationally.
- Predicts the next PC with an agree predictor: a direct-mapped BTB that stores a bias bit per branch, plus a PHT of 2-bit agree counters indexed by PC xor a global history register (GHR).
- Drives the IF/ID pipeline register that feeds decode's `i_instr_d`, `i_pc_d`, `i_pc_four_d`, `i_predicted_pc_d` and `i_taken_d`.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries (power of 2). BI = log2(BTB_ENTRIES).
- PHT_ENTRIES, 16, number of 2-bit agree counters (power of 2). PI = log2(PHT_ENTRIES).
- GHR_BITS, 4, global history length. Must be ≤ PI.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_stall_f  in  1  hold the PC.
- i_stall_d  in  1  hold the IF/ID register.
- i_flush_d  in  1  clear the IF/ID register (bubble).
- i_redirect_e  in  1  execute detected a mispredict.
- i_redirect_pc_e  in  32  correct next PC.
- i_upd_vld_e  in  1  a branch or jump resolved in execute this cycle.
- i_upd_pc_e  in  32  PC of the resolved instruction.
- i_upd_target_e  in  32  resolved target.
- i_upd_taken_e  in  1  resolved direction.
- i_upd_is_jump_e  in  1  resolved instruction is JAL/JALR.
- i_imem_rdata  in  32  instruction at o_imem_addr, same cycle.
- o_imem_addr  out  32  current PC.
- o_instr_d  out  32  registered instruction.
- o_pc_d  out  32  registered PC.
- o_pc_four_d  out  32  registered PC+4.
- o_predicted_pc_d  out  32  registered predicted next PC.
- o_taken_d  out  1  registered predicted-taken flag.

Behaviour:
Reset (i_rst_n=0 at a rising edge):
- PC=RESET_PC.
- All o_*_d outputs = 0.
- All BTB valid bits = 0.
- All PHT counters = 2'b10 (weakly agree).
- GHR = 0.
- Reset asserted mid-operation overrides every other input on that edge. No partial updates occur.

Lookup (combinational on the PC):
- o_imem_addr = PC.
- BTB index = PC[BI+1:2]; tag = PC[31:BI+2].
- hit = valid & (tag match).
- PHT index = PC[PI+1:2] xor zero-extended GHR.
- agree = counter[1].
- taken_f = hit & (is_jump | (bias == agree)).
- pred_pc = taken_f ? btb_target : PC+4. PC+4 wraps modulo 2^32.

Next-PC priority:
1. Reset.
2. i_redirect_e → i_redirect_pc_e. This applies even if i_stall_f is asserted.
3. i_stall_f → PC held.
4. Otherwise → pred_pc.

IF/ID register priority:
1. Reset.
2. i_flush_d → all outputs 0.
3. i_stall_d → hold.
4. Otherwise load i_imem_rdata, PC, PC+4, pred_pc, taken_f.
- Redirect does not clear IF/ID by itself. The hazard unit asserts i_flush_d alongside it.

Update (when i_upd_vld_e=1):
- Index the BTB and PHT from i_upd_pc_e, using the GHR value before this edge's shift.
- BTB hit: rewrite the target.
- BTB miss with i_upd_taken_e=1: allocate the entry (valid=1, tag, target, bias=i_upd_taken_e, is_jump=i_upd_is_jump_e). The PHT counter at the index is set to 2'b10.
- BTB miss with not taken: no BTB write.
- Bias is written only at allocation. It is never changed on a hit.
- Conditional branch that hits: the counter increments (saturating at 3) if taken==bias, otherwise decrements (saturating at 0).
- Jumps do not touch the PHT or GHR.
- GHR shift on conditional branches only: GHR <= {GHR[GHR_BITS-2:0], i_upd_taken_e}. This happens whether the branch hit or missed.

Simultaneous events:
- Lookup and update to the same entry in one cycle: the lookup sees the pre-update contents. The write takes effect at the edge.
- Redirect and update in the same cycle: both are applied.

Test Plan:
- Reset then run with no stalls, BTB empty, i_imem_rdata=32'h00000013 → PC sequence 0,4,8. o_pc_d=0 and o_pc_four_d=4 one cycle after the first fetch. o_taken_d=0.
- Update pc=0x40, target=0x100, taken=1, not a jump; next fetch at PC 0x40 → o_taken_d=1, o_predicted_pc_d=0x100, next PC=0x100.
- Same branch resolved not-taken twice, with GHR held by setting GHR_BITS-consistent history → counter 2→1→0. Next fetch at 0x40 predicts not-taken and uses 0x44.
- i_stall_f=1 and i_stall_d=1 for 3 cycles at PC=0x8 → PC and all o_*_d are unchanged. On release, fetch resumes at 0x8's prediction.
- i_stall_f=1 with i_redirect_e=1, redirect_pc=0x200, and i_flush_d=1 → next PC=0x200 and o_instr_d=0. The following cycle o_pc_d=0x200.
- i_rst_n=0 for one edge mid-stream at PC=0x100 with a valid BTB entry → PC=0, all outputs 0, and a fetch at 0x40 no longer predicts taken.
